riscv_main_fsm: RTL and testbench
=================================

RISCV_MAIN_FSM -- requirements
Module: riscv_main_fsm

Interface
REQ-001 Parameters: none; opcode_e and state encodings SHALL come from riscv_pkg.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rstn_i  in  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-004 opcode_i  in  7 (opcode_e)  instruction opcode: OP_L 0000011, OP_S 0100011, OP_R 0110011, OP_B 1100011, OP_I 0010011, OP_JAL 1101111; any other value is invalid (OP_INVALID).
REQ-005 Zero_i  in  1  ALU zero flag.
REQ-006 Branch_o  out  1  branch-instruction state indicator.
REQ-007 PCUpdate_o  out  1  unconditional PC write request.
REQ-008 PCWrite_o  out  1  PC register write enable.
REQ-009 RegWrite_o, MemWrite_o, IRWrite_o  out  1 each  register-file, memory and instruction-register write enables.
REQ-010 ResultSrc_o  out  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult.
REQ-011 ALUSrcA_o  out  2  ALU A select: 00 PC, 01 OldPC, 10 RD1.
REQ-012 ALUSrcB_o  out  2  ALU B select: 00 RD2, 01 ImmExt, 10 constant 4.
REQ-013 AdrSrc_o  out  1  memory address select: 0 PC, 1 Result.
REQ-014 ALUOp_o  out  2  00 add, 01 subtract/compare, 10 decode by funct.

Function
REQ-015 Moore FSM; all outputs except PCWrite_o SHALL depend only on the current state.
REQ-016 States (4-bit): S_FETCH 0, S_DECODE 1, S_MEMADR 2, S_MEMREAD 3, S_MEMWB 4, S_MEMWRITE 5, S_EXECUTER 6, S_ALUWB 7, S_EXECUTEI 8, S_JAL 9, S_BEQ 10; unused codes SHALL go to S_FETCH.
REQ-017 Registers "state" and combinational "next_state" SHALL exist under those names for hierarchical observation.
REQ-018 Transitions: FETCH->DECODE unconditionally.
REQ-019 DECODE-> MEMADR (OP_L or OP_S), EXECUTER (OP_R), EXECUTEI (OP_I), JAL (OP_JAL), BEQ (OP_B), FETCH (any other opcode).
REQ-020 MEMADR-> MEMREAD (OP_L), MEMWRITE (OP_S), else FETCH.
REQ-021 MEMREAD->MEMWB; MEMWB->FETCH; MEMWRITE->FETCH; EXECUTER->ALUWB; EXECUTEI->ALUWB; JAL->ALUWB; ALUWB->FETCH; BEQ->FETCH.
REQ-022 Output default SHALL be 0 for every output; only listed fields differ per state:
- FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10, PCUpdate 1.
- DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00.
- MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
- MEMREAD: ResultSrc 00, AdrSrc 1.
- MEMWB: ResultSrc 01, RegWrite 1.
- MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1.
- EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
- EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
- ALUWB: ResultSrc 00, RegWrite 1.
- JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1.
- BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1.
REQ-023 PCWrite_o SHALL equal PCUpdate_o OR (Branch_o AND Zero_i), combinationally, same cycle.
REQ-024 opcode_i SHALL be sampled only in DECODE and MEMADR; changes in other states have no effect.
REQ-025 Instruction latency: lw 5 cycles, sw 4, R/I-type 4, jal 4, beq 3, invalid 2 (FETCH, DECODE).

Reset
REQ-026 rstn_i=1 SHALL force state to S_FETCH immediately, independent of clk_i.
REQ-027 While in reset, outputs SHALL show FETCH values (IRWrite 1, PCUpdate 1, PCWrite 1, ALUSrcB 10, ResultSrc 10, all others 0).
REQ-028 Reset mid-instruction SHALL abort it; first cycle after release is S_FETCH, then S_DECODE.

Verification
REQ-029 Reset, then opcode OP_INVALID -> FETCH/DECODE alternate, RegWrite_o and MemWrite_o never 1.
REQ-030 OP_L -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite_o=1 and ResultSrc_o=01 only in MEMWB; AdrSrc_o=1 in MEMREAD.
REQ-031 OP_S -> FETCH, DECODE, MEMADR, MEMWRITE, FETCH; MemWrite_o=1 only in MEMWRITE.
REQ-032 OP_R then OP_I -> EXECUTER (ALUSrcB 00, ALUOp 10) / EXECUTEI (ALUSrcB 01, ALUOp 10), each followed by ALUWB with RegWrite_o=1.
REQ-033 OP_B in BEQ: Zero_i=0 -> PCWrite_o=0; Zero_i=1 -> PCWrite_o=1; Branch_o=1, ALUOp_o=01 in both cases.
REQ-034 OP_JAL -> JAL state with PCUpdate_o=PCWrite_o=1, ALUSrcA 01, ALUSrcB 10, then ALUWB, then FETCH; reset asserted in JAL -> S_FETCH without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_main_fsm_if.sv
// Control bus between the multicycle RISC-V main decoder FSM and its datapath.
// Carries opcode_i/Zero_i into the FSM and all datapath control strobes out of it.
interface riscv_main_fsm_if;
    logic [6:0] opcode_i;
    logic       Zero_i;
    logic       Branch_o;
    logic       PCUpdate_o;
    logic       PCWrite_o;
    logic       RegWrite_o;
    logic       MemWrite_o;
    logic       IRWrite_o;
    logic [1:0] ResultSrc_o;
    logic [1:0] ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic       AdrSrc_o;
    logic [1:0] ALUOp_o;

    modport master (
        output opcode_i, Zero_i,
        input  Branch_o, PCUpdate_o, PCWrite_o,
        input  RegWrite_o, MemWrite_o, IRWrite_o,
        input  ResultSrc_o, ALUSrcA_o, ALUSrcB_o,
        input  AdrSrc_o, ALUOp_o
    );

    modport slave (
        input  opcode_i, Zero_i,
        output Branch_o, PCUpdate_o, PCWrite_o,
        output RegWrite_o, MemWrite_o, IRWrite_o,
        output ResultSrc_o, ALUSrcA_o, ALUSrcB_o,
        output AdrSrc_o, ALUOp_o
    );
endinterface

// File: rtl/riscv_main_fsm.sv
// Multicycle RISC-V main control FSM (Moore) plus its opcode/state package.
// Ports: clk_i, rstn_i (async, active-high), bus (riscv_main_fsm_if.slave).
package riscv_pkg;
    typedef enum logic [6:0] {
        OP_INVALID = 7'b0000000,
        OP_L       = 7'b0000011,
        OP_I       = 7'b0010011,
        OP_S       = 7'b0100011,
        OP_R       = 7'b0110011,
        OP_B       = 7'b1100011,
        OP_JAL     = 7'b1101111
    } opcode_e;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_e;
endpackage

module riscv_main_fsm
    import riscv_pkg::*;
(
    input  logic               clk_i,
    input  logic               rstn_i,
    riscv_main_fsm_if.slave    bus
);

    state_e     state;
    state_e     next_state;

    logic       w_branch;
    logic       w_pcupdate;
    logic       w_regwrite;
    logic       w_memwrite;
    logic       w_irwrite;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic       w_adrsrc;
    logic [1:0] w_aluop;

    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // opcode only matters in DECODE and MEMADR; elsewhere it is ignored
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = S_DECODE;
            S_DECODE: begin
                case (bus.opcode_i)
                    OP_L, OP_S: next_state = S_MEMADR;
                    OP_R:       next_state = S_EXECUTER;
                    OP_I:       next_state = S_EXECUTEI;
                    OP_JAL:     next_state = S_JAL;
                    OP_B:       next_state = S_BEQ;
                    default:    next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                case (bus.opcode_i)
                    OP_L:    next_state = S_MEMREAD;
                    OP_S:    next_state = S_MEMWRITE;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI,
            S_JAL:      next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_branch    = 1'b0;
        w_pcupdate  = 1'b0;
        w_regwrite  = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_adrsrc    = 1'b0;
        w_aluop     = 2'b00;
        case (state)
            S_FETCH: begin
                w_irwrite   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_pcupdate  = 1'b1;
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTER: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b10;
            end
            S_EXECUTEI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = 2'b10;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
            end
            S_JAL: begin
                w_alusrca  = 2'b01;
                w_alusrcb  = 2'b10;
                w_pcupdate = 1'b1;
            end
            S_BEQ: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b01;
                w_branch  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.Branch_o    = w_branch;
    assign bus.PCUpdate_o  = w_pcupdate;
    // the only Mealy term: a taken branch writes the PC in the same cycle
    assign bus.PCWrite_o   = w_pcupdate | (w_branch & bus.Zero_i);
    assign bus.RegWrite_o  = w_regwrite;
    assign bus.MemWrite_o  = w_memwrite;
    assign bus.IRWrite_o   = w_irwrite;
    assign bus.ResultSrc_o = w_resultsrc;
    assign bus.ALUSrcA_o   = w_alusrca;
    assign bus.ALUSrcB_o   = w_alusrcb;
    assign bus.AdrSrc_o    = w_adrsrc;
    assign bus.ALUOp_o     = w_aluop;

endmodule

// File: tb/tb_riscv_main_fsm.sv
// Randomized self-checking bench for riscv_main_fsm.
// Model: per-instruction state sequences and per-state control vectors.
module tb_riscv_main_fsm;

    localparam logic [6:0] C_L   = 7'b0000011;
    localparam logic [6:0] C_S   = 7'b0100011;
    localparam logic [6:0] C_R   = 7'b0110011;
    localparam logic [6:0] C_B   = 7'b1100011;
    localparam logic [6:0] C_I   = 7'b0010011;
    localparam logic [6:0] C_JAL = 7'b1101111;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    riscv_main_fsm_if bus ();

    riscv_main_fsm dut (
        .clk_i  (clk),
        .rstn_i (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // {Branch,PCUpdate,RegWrite,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,AdrSrc,ALUOp}
    function automatic logic [13:0] exp_out(input int st);
        logic br, pu, rw, mw, ir, ad;
        logic [1:0] rs, sa, sb, op;
        {br, pu, rw, mw, ir, ad} = 6'b0;
        {rs, sa, sb, op} = 8'b0;
        case (st)
            0:  begin ir = 1; sb = 2'b10; rs = 2'b10; pu = 1; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  begin ad = 1; end
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin ad = 1; mw = 1; end
            6:  begin sa = 2'b10; op = 2'b10; end
            7:  begin rw = 1; end
            8:  begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
            9:  begin sa = 2'b01; sb = 2'b10; pu = 1; end
            10: begin sa = 2'b10; op = 2'b01; br = 1; end
            default: ;
        endcase
        return {br, pu, rw, mw, ir, rs, sa, sb, ad, op};
    endfunction

    function automatic logic [13:0] dut_out();
        return {bus.Branch_o, bus.PCUpdate_o, bus.RegWrite_o,
                bus.MemWrite_o, bus.IRWrite_o, bus.ResultSrc_o,
                bus.ALUSrcA_o, bus.ALUSrcB_o, bus.AdrSrc_o, bus.ALUOp_o};
    endfunction

    function automatic logic [6:0] rand_invalid();
        logic [6:0] v;
        do v = 7'($urandom);
        while (v == C_L || v == C_S || v == C_R || v == C_B ||
               v == C_I || v == C_JAL);
        return v;
    endfunction

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 7))
            0: return C_L;
            1: return C_S;
            2: return C_R;
            3: return C_B;
            4: return C_I;
            5: return C_JAL;
            default: return rand_invalid();
        endcase
    endfunction

    // Called at a negedge while the DUT sits in FETCH; returns at the
    // negedge on which the next instruction's FETCH is visible.
    task automatic run_instr(input logic [6:0] op, input logic [6:0] op2,
                             input bit abort);
        int s[$];
        logic [13:0] e;
        s = {0, 1};
        if (op == C_L || op == C_S) begin
            s.push_back(2);
            if (op2 == C_L) begin
                s.push_back(3);
                s.push_back(4);
            end else if (op2 == C_S) begin
                s.push_back(5);
            end
        end else if (op == C_R) begin
            s.push_back(6); s.push_back(7);
        end else if (op == C_I) begin
            s.push_back(8); s.push_back(7);
        end else if (op == C_JAL) begin
            s.push_back(9); s.push_back(7);
        end else if (op == C_B) begin
            s.push_back(10);
        end
        for (int k = 0; k < s.size(); k++) begin
            if (k == 1)
                bus.opcode_i = op;
            else if (s[k] == 2)
                bus.opcode_i = op2;
            else
                bus.opcode_i = 7'($urandom);
            bus.Zero_i = 1'($urandom);
            #1;
            e = exp_out(s[k]);
            chk("state", 32'(dut.state), 32'(s[k]));
            chk("ctrl", 32'(dut_out()), 32'(e));
            chk("pcwrite", 32'(bus.PCWrite_o),
                32'(e[12] | (e[13] & bus.Zero_i)));
            if (abort && s[k] == 9) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_async_state", 32'(dut.state), 32'd0);
                chk("rst_ctrl", 32'(dut_out()), 32'(exp_out(0)));
                chk("rst_pcwrite", 32'(bus.PCWrite_o), 32'd1);
                @(negedge clk);
                chk("rst_hold_state", 32'(dut.state), 32'd0);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [6:0] op;
        logic [6:0] op2;
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.opcode_i = C_R;
        bus.Zero_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", 32'(dut.state), 32'd0);
        chk("reset_ctrl", 32'(dut_out()), 32'(exp_out(0)));
        chk("reset_pcwrite", 32'(bus.PCWrite_o), 32'd1);
        rst = 1'b0;

        run_instr(rand_invalid(), 7'd0, 1'b0);
        run_instr(rand_invalid(), 7'd0, 1'b0);
        run_instr(C_L, C_L, 1'b0);
        run_instr(C_S, C_S, 1'b0);
        run_instr(C_R, C_R, 1'b0);
        run_instr(C_I, C_I, 1'b0);
        run_instr(C_B, C_B, 1'b0);
        run_instr(C_JAL, C_JAL, 1'b0);
        run_instr(C_L, C_R, 1'b0);
        run_instr(C_S, C_L, 1'b0);
        run_instr(C_L, C_S, 1'b0);

        for (int n = 0; n < 150; n++) begin
            op = rand_op();
            op2 = op;
            if ($urandom_range(0, 9) == 0)
                op2 = rand_op();
            run_instr(op, op2, 1'b0);
        end

        run_instr(C_JAL, C_JAL, 1'b1);
        run_instr(C_B, C_B, 1'b0);
        run_instr(C_JAL, C_JAL, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
